// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: data width, FSM states
// and the byte-enable merge helper.
package data_mem_responder_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Replace only the bytes of old_word whose enable bit is set.
  function automatic logic [DATA_W-1:0] merge_be(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] wdata,
    input logic [BE_W-1:0]   be
  );
    logic [DATA_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < int'(BE_W); i++) begin
      if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/data_mem_responder_dmem_array.sv
// Word-addressed storage with byte-enabled synchronous write and
// combinational read; contents start at zero and are never reset.
module dmem_array
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [BE_W-1:0]   i_be,
  output logic [DATA_W-1:0] o_rdata_c
);

  logic [DATA_W-1:0] r_mem [DEPTH_WORDS] = '{default: '0};

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_idx] <= merge_be(r_mem[i_idx], i_wdata, i_be);
  end

  assign o_rdata_c = r_mem[i_idx];

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder: accepts one access in IDLE, waits
// WAIT_CYCLES cycles, then holds the response until the pipeline consumes it.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
  localparam logic [CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  logic              r_write;
  logic              r_err;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;

  logic              r_req_ready;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic [DATA_W-1:0] r_resp_rdata;

  logic              w_req_err;
  logic              w_accept;
  logic              w_enter_resp;
  logic              w_src_idle;
  logic              w_write;
  logic              w_err;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_wdata;
  logic [BE_W-1:0]   w_be;
  logic              w_mem_we;
  logic [DATA_W-1:0] w_mem_rdata;

  assign w_req_err = (req_addr[1:0] != 2'b00) || ({1'b0, req_addr} >= ADDR_LIMIT);
  assign w_accept  = (r_state == IDLE) && req_valid;

  // Next state and wait counter.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            w_state_nxt = RESP;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (r_cnt == '0) w_state_nxt = RESP;
        else             w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      RESP: begin
        if (resp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_write <= req_write;
      r_err   <= w_req_err;
      r_idx   <= req_addr[IDX_W+1:2];
      r_wdata <= req_wdata;
      r_be    <= req_be;
    end
  end

  // With zero wait states the access completes on the acceptance edge itself,
  // so the request fields are used straight from the ports.
  assign w_src_idle   = (r_state == IDLE);
  assign w_write      = w_src_idle ? req_write           : r_write;
  assign w_err        = w_src_idle ? w_req_err           : r_err;
  assign w_idx        = w_src_idle ? req_addr[IDX_W+1:2] : r_idx;
  assign w_wdata      = w_src_idle ? req_wdata           : r_wdata;
  assign w_be         = w_src_idle ? req_be              : r_be;
  assign w_enter_resp = (w_state_nxt == RESP) && (r_state != RESP);
  assign w_mem_we     = w_enter_resp && !reset && w_write && !w_err;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_dmem_array (
    .i_clk     (clock),
    .i_we      (w_mem_we),
    .i_idx     (w_idx),
    .i_wdata   (w_wdata),
    .i_be      (w_be),
    .o_rdata_c (w_mem_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_req_ready <= (w_state_nxt == IDLE);
      if (w_enter_resp) begin
        r_resp_valid <= 1'b1;
        r_resp_err   <= w_err;
        r_resp_rdata <= (w_write || w_err) ? '0 : w_mem_rdata;
      end else if ((r_state == RESP) && resp_ready) begin
        r_resp_valid <= 1'b0;
        r_resp_err   <= 1'b0;
        r_resp_rdata <= '0;
      end
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: responder with two wait states (unit 0) and with none
// (unit 1), sharing request fields but with independent handshakes.
module tb_data_mem_responder;

  logic        clk;
  logic        reset;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        req_valid  [2];
  logic        resp_ready [2];
  logic        req_ready  [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  int n_checks = 0;
  int n_pass   = 0;

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
    .clock      (clk),
    .reset      (reset),
    .req_valid  (req_valid[0]),
    .req_ready  (req_ready[0]),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .resp_valid (resp_valid[0]),
    .resp_ready (resp_ready[0]),
    .resp_rdata (resp_rdata[0]),
    .resp_err   (resp_err[0])
  );

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
    .clock      (clk),
    .reset      (reset),
    .req_valid  (req_valid[1]),
    .req_ready  (req_ready[1]),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .resp_valid (resp_valid[1]),
    .resp_ready (resp_ready[1]),
    .resp_rdata (resp_rdata[1]),
    .resp_err   (resp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // One complete access on unit u. hold>0 keeps resp_ready low for that many
  // cycles once the response appears, pulsing a stray store each cycle.
  task automatic access(input int u, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be, input int hold,
                        output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    req_write = wr; req_addr = a; req_wdata = wd; req_be = be;
    req_valid[u] = 1'b1;
    @(posedge clk); #1;
    req_valid[u] = 1'b0;
    lat = 1;
    while (!resp_valid[u] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = resp_rdata[u];
    er = resp_err[u];
    for (int i = 0; i < hold; i++) begin
      check($sformatf("hold_valid%0d", i), 32'(resp_valid[u]), 32'd1);
      check($sformatf("hold_rdata%0d", i), resp_rdata[u], rd);
      check($sformatf("hold_ready%0d", i), 32'(req_ready[u]), 32'd0);
      req_write = 1'b1; req_addr = a; req_wdata = 32'h0; req_be = 4'hF;
      req_valid[u] = 1'b1;
      @(posedge clk); #1;
    end
    req_valid[u] = 1'b0;
    resp_ready[u] = 1'b1;
    @(posedge clk); #1;
    resp_ready[u] = 1'b0;
    check("post_resp_ready", 32'(req_ready[u]), 32'd1);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    reset = 1'b1;
    req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    for (int i = 0; i < 2; i++) begin req_valid[i] = 1'b0; resp_ready[i] = 1'b0; end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_req_ready",  32'(req_ready[0]), 32'd1);
    check("rst_resp_valid", 32'(resp_valid[0]), 32'd0);
    check("rst_resp_rdata", resp_rdata[0], 32'h0);
    check("rst_resp_err",   32'(resp_err[0]), 32'd0);

    access(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
    check("st10_err", 32'(er), 32'd0);
    check("st10_rdata", rd, 32'h0);
    check("st10_lat", 32'(lat), 32'd3);

    access(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    check("ld10_rdata", rd, 32'hDEADBEEF);
    check("ld10_err", 32'(er), 32'd0);
    check("ld10_lat", 32'(lat), 32'd3);

    access(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, 0, rd, er, lat);
    access(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    check("ld10_be0", rd, 32'hDEADBEAA);

    access(0, 1'b1, 32'h10, 32'h5500CC00, 4'b1010, 0, rd, er, lat);
    access(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    check("ld10_be31", rd, 32'h55ADCCAA);

    access(0, 1'b0, 32'h13, 32'h0, 4'h0, 0, rd, er, lat);
    check("ld13_err", 32'(er), 32'd1);
    check("ld13_rdata", rd, 32'h0);
    access(0, 1'b0, 32'h400, 32'h0, 4'h0, 0, rd, er, lat);
    check("ld400_err", 32'(er), 32'd1);
    check("ld400_rdata", rd, 32'h0);
    access(0, 1'b1, 32'h12, 32'hFFFFFFFF, 4'hF, 0, rd, er, lat);
    check("st12_err", 32'(er), 32'd1);
    access(0, 1'b1, 32'h410, 32'hFFFFFFFF, 4'hF, 0, rd, er, lat);
    check("st410_err", 32'(er), 32'd1);
    access(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    check("ld10_after_err", rd, 32'h55ADCCAA);

    access(0, 1'b1, 32'h3FC, 32'h11223344, 4'hF, 0, rd, er, lat);
    check("st3fc_err", 32'(er), 32'd0);
    access(0, 1'b0, 32'h3FC, 32'h0, 4'h0, 0, rd, er, lat);
    check("ld3fc_rdata", rd, 32'h11223344);
    access(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, rd, er, lat);
    check("ld0_alias", rd, 32'h0);

    access(0, 1'b0, 32'h10, 32'h0, 4'h0, 5, rd, er, lat);
    check("hold_first_rdata", rd, 32'h55ADCCAA);
    access(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    check("ld10_after_hold", rd, 32'h55ADCCAA);

    // Reset while a store to 0x20 sits in WAIT.
    @(negedge clk);
    req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_be = 4'hF;
    req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    check("wait_req_ready", 32'(req_ready[0]), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rstwait_resp_valid", 32'(resp_valid[0]), 32'd0);
    check("rstwait_req_ready", 32'(req_ready[0]), 32'd1);
    repeat (4) @(posedge clk);
    #1 check("rstwait_no_resp", 32'(resp_valid[0]), 32'd0);
    access(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat);
    check("ld20_discarded", rd, 32'h0);

    access(1, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    check("w0_ld10_lat", 32'(lat), 32'd1);
    check("w0_ld10_rdata", rd, 32'h0);
    access(1, 1'b1, 32'h8, 32'hCAFEF00D, 4'hF, 0, rd, er, lat);
    check("w0_st8_lat", 32'(lat), 32'd1);
    access(1, 1'b0, 32'h8, 32'h0, 4'h0, 0, rd, er, lat);
    check("w0_ld8_rdata", rd, 32'hCAFEF00D);
    access(1, 1'b0, 32'h7, 32'h0, 4'h0, 0, rd, er, lat);
    check("w0_ld7_err", 32'(er), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words stored.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, number of wait states inserted per access (legal range 0-15).
REQ-003 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  pipeline presents an access.
REQ-006 SHALL have port req_ready  output  1  responder can accept an access this cycle.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data.
REQ-010 SHALL have port req_be  input  4  store byte enables; bit i enables byte i (bits 8i+7:8i).
REQ-011 SHALL have port resp_valid  output  1  response available.
REQ-012 SHALL have port resp_ready  input  1  pipeline consumes the response.
REQ-013 SHALL have port resp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 SHALL have port resp_err  output  1  access was misaligned or out of range.

Function
REQ-015 SHALL implement states IDLE, WAIT, RESP.
REQ-016 In IDLE, req_ready SHALL be 1; in WAIT and RESP it SHALL be 0.
REQ-017 A request SHALL be accepted on an edge where state is IDLE and req_valid=1; req_write, req_addr, req_wdata, req_be SHALL be captured on that edge.
REQ-018 On acceptance, state SHALL go to WAIT with the wait counter loaded to WAIT_CYCLES-1, or directly to RESP when WAIT_CYCLES=0.
REQ-019 In WAIT, the counter SHALL decrement each cycle; at count 0, state SHALL go to RESP on the next edge.
REQ-020 resp_valid SHALL first be 1 exactly WAIT_CYCLES+1 cycles after the acceptance cycle, and SHALL remain 1, with resp_rdata/resp_err stable, until an edge with resp_ready=1.
REQ-021 On an edge in RESP with resp_ready=1, state SHALL return to IDLE; at least one IDLE cycle therefore separates consecutive accesses.
REQ-022 Word index SHALL be captured addr bits [log2(DEPTH_WORDS)+1:2].
REQ-023 An access with addr[1:0] != 0 or addr >= 4*DEPTH_WORDS SHALL set resp_err=1, resp_rdata=0, and SHALL NOT modify memory.
REQ-024 A valid store SHALL update only enabled bytes, on the edge entering RESP; resp_rdata SHALL be 0.
REQ-025 A valid load SHALL latch the addressed word into resp_rdata on the edge entering RESP, reflecting all previously completed stores.
REQ-026 req_valid while not in IDLE SHALL be ignored (no capture, no side effect).

Reset
REQ-027 reset=1 on an edge SHALL force state IDLE, counter 0, resp_valid=0, resp_err=0, resp_rdata=0, req_ready=1 after that edge, including mid-WAIT or mid-RESP; an in-flight store not yet committed SHALL be discarded.
REQ-028 Memory contents SHALL be unaffected by reset and SHALL be zero at simulation start.

Structure
REQ-029 State encodings and the data-width constant (32) SHALL live in the shared pipeline include file.
REQ-030 The storage array with byte-enabled write SHALL be a sub-module named dmem_array; control FSM stays in data_mem_responder.

Verification
REQ-031 Store addr 0x10, wdata 0xDEADBEEF, be 4'hF, then load 0x10 -> load resp_rdata=0xDEADBEEF, resp_err=0, resp_valid 3 cycles after acceptance (WAIT_CYCLES=2).
REQ-032 Store addr 0x10, wdata 0x000000AA, be 4'b0001 over 0xDEADBEEF, then load -> 0xDEADBEAA.
REQ-033 Load addr 0x13 and load addr 0x400 (DEPTH_WORDS=256) -> resp_err=1, resp_rdata=0; subsequent load 0x10 unchanged.
REQ-034 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_rdata stable 5 cycles; req_valid pulsed meanwhile not accepted.
REQ-035 Assert reset during WAIT of a store to 0x20 (wdata 0x12345678) -> resp_valid=0, req_ready=1 next cycle; later load 0x20 returns prior value 0.
REQ-036 WAIT_CYCLES=0: load accepted -> resp_valid=1 in the very next cycle.
